// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter
// Purpose : Round-robin arbiter giving two requesters access to one BRAM port.
// Revision: 1.0
// ============================================================================
module bram_port_arbiter #(
   parameter int DEPTH = 50
) (
   input  logic        CLK,
   input  logic        RSTN,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,

   output logic [31:0] addrb,
   output logic [31:0] dinb,
   input  logic [31:0] doutb,
   output logic        enb,
   output logic [3:0]  web,

   output logic        busy
);

   localparam logic [31:0] c_DEPTH = 32'(DEPTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      RD2  = 3'd3,
      WR   = 3'd4,
      ERR  = 3'd5,
      RSP  = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_last;
   logic        r_id;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_acc;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic        w_bad;
   logic        w_rsp;
   logic        w_rd_data;

   // r_last holds the id granted most recently; on a tie the other side wins.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_state == IDLE) begin
         if (req0_valid && req1_valid) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
         end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
         end
      end
      w_acc       = w_gnt0 | w_gnt1;
      w_sel_we    = w_gnt1 ? req1_we    : req0_we;
      w_sel_addr  = w_gnt1 ? req1_addr  : req0_addr;
      w_sel_wdata = w_gnt1 ? req1_wdata : req0_wdata;
      w_bad       = (w_sel_addr >= c_DEPTH);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               if (w_bad)         w_next = ERR;
               else if (w_sel_we) w_next = WR;
               else               w_next = RD0;
            end
         end
         RD0:     w_next = RD1;
         RD1:     w_next = RD2;
         RD2:     w_next = RSP;
         WR:      w_next = RSP;
         ERR:     w_next = IDLE;
         RSP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_last  <= w_gnt1;
            r_id    <= w_gnt1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end
         // Two BRAM register stages put the word on doutb during RD2.
         if (r_state == RD2) begin
            r_rdata <= doutb;
         end
      end
   end

   always_comb begin
      req0_ready = w_gnt0;
      req1_ready = w_gnt1;
      busy       = (r_state != IDLE);

      enb   = (r_state == RD0) || (r_state == RD1) || (r_state == RD2) || (r_state == WR);
      web   = (r_state == WR) ? 4'hF : 4'h0;
      addrb = enb ? r_addr : 32'd0;
      dinb  = (r_state == WR) ? r_wdata : 32'd0;

      w_rsp     = (r_state == RSP) || (r_state == ERR);
      w_rd_data = (r_state == RSP) && !r_we;

      rsp0_valid = w_rsp && !r_id;
      rsp1_valid = w_rsp &&  r_id;
      rsp0_err   = (r_state == ERR) && !r_id;
      rsp1_err   = (r_state == ERR) &&  r_id;
      rsp0_rdata = (w_rd_data && !r_id) ? r_rdata : 32'd0;
      rsp1_rdata = (w_rd_data &&  r_id) ? r_rdata : 32'd0;
   end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// Testbench for bram_port_arbiter: BRAM model, transaction-level reference
// model, table-driven vectors, directed corner cases and random traffic.
module tb_bram_port_arbiter;

   localparam int DEPTH = 50;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic        rsp0_valid, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp1_valid, rsp1_err;
   logic [31:0] rsp1_rdata;
   logic [31:0] addrb, dinb, doutb;
   logic        enb;
   logic [3:0]  web;
   logic        busy;

   bram_port_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   // BRAM: two enb-gated register stages on the read path.
   logic [31:0] mem [64];
   logic [31:0] s1 = 32'd0, s2 = 32'd0;
   bit          preloaded = 1'b0;
   assign doutb = s2;
   always @(posedge CLK) begin
      if (!preloaded) begin
         for (int i = 0; i < 64; i++) mem[i] = 32'd0;
         mem[1]    = 32'd15;
         mem[49]   = 32'd777;
         preloaded = 1'b1;
      end
      if (enb) begin
         s1 <= mem[addrb[5:0]];
         s2 <= s1;
         if (web == 4'hF) mem[addrb[5:0]] = dinb;
      end
   end

   // Requester intent
   bit          p_valid [2];
   bit          p_we    [2];
   logic [31:0] p_addr  [2];
   logic [31:0] p_wdata [2];

   // Reference model: one transaction in flight with a fixed latency
   int          cyc;
   bit          m_act;
   int          m_t, m_lat, m_id, m_last;
   bit          m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [31:0] ref_mem [64];

   bit          obs_seen  [2];
   bit          obs_err   [2];
   logic [31:0] obs_rdata [2];
   int          obs_cyc   [2];
   int          acc_cyc   [2];
   int          dut_grants[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_inputs();
      req0_valid = p_valid[0]; req0_we = p_we[0]; req0_addr = p_addr[0]; req0_wdata = p_wdata[0];
      req1_valid = p_valid[1]; req1_we = p_we[1]; req1_addr = p_addr[1]; req1_wdata = p_wdata[1];
   endtask

   task automatic step();
      int          g;
      bit          busy_e, enb_e;
      bit          rv_e [2];
      logic [3:0]  web_e;
      logic [31:0] addrb_e, dinb_e;
      @(negedge CLK);
      drive_inputs();
      #1;
      if (m_act && cyc > m_t + m_lat) m_act = 1'b0;
      busy_e = m_act;
      g = -1;
      if (!busy_e) begin
         if (p_valid[0] && p_valid[1]) g = (m_last == 0) ? 1 : 0;
         else if (p_valid[0])          g = 0;
         else if (p_valid[1])          g = 1;
      end
      rv_e[0] = busy_e && (cyc == m_t + m_lat) && (m_id == 0);
      rv_e[1] = busy_e && (cyc == m_t + m_lat) && (m_id == 1);
      enb_e   = busy_e && !m_err && (m_we ? (cyc == m_t + 1) : (cyc <= m_t + 3));
      web_e   = (busy_e && m_we && !m_err && cyc == m_t + 1) ? 4'hF : 4'h0;
      addrb_e = enb_e ? m_addr : 32'd0;
      dinb_e  = (web_e == 4'hF) ? m_wdata : 32'd0;

      chk("ctrl", {req1_ready, req0_ready, busy, rsp1_valid, rsp1_err, rsp0_valid, rsp0_err, enb, web},
                  {g == 1, g == 0, busy_e, rv_e[1], rv_e[1] && m_err, rv_e[0], rv_e[0] && m_err, enb_e, web_e});
      chk("bram_bus", {addrb, dinb}, {addrb_e, dinb_e});
      if (rv_e[0]) chk("rsp0_rdata", rsp0_rdata, m_rdata);
      if (rv_e[1]) chk("rsp1_rdata", rsp1_rdata, m_rdata);

      if (rsp0_valid) begin obs_seen[0] = 1; obs_err[0] = rsp0_err; obs_rdata[0] = rsp0_rdata; obs_cyc[0] = cyc; end
      if (rsp1_valid) begin obs_seen[1] = 1; obs_err[1] = rsp1_err; obs_rdata[1] = rsp1_rdata; obs_cyc[1] = cyc; end
      if (req0_ready) dut_grants.push_back(0);
      if (req1_ready) dut_grants.push_back(1);

      if (g >= 0) begin
         m_act   = 1'b1;
         m_t     = cyc;
         m_id    = g;
         m_we    = p_we[g];
         m_addr  = p_addr[g];
         m_wdata = p_wdata[g];
         m_err   = (p_addr[g] >= DEPTH);
         m_lat   = m_err ? 1 : (m_we ? 2 : 4);
         m_rdata = (m_err || m_we) ? 32'd0 : ref_mem[m_addr[5:0]];
         if (!m_err && m_we) ref_mem[m_addr[5:0]] = m_wdata;
         m_last  = g;
         acc_cyc[g] = cyc;
         p_valid[g] = 1'b0;
      end
      cyc++;
   endtask

   // Asserts reset in the middle of the current cycle and checks the outputs
   // clear without waiting for a clock edge.
   task automatic apply_reset();
      p_valid[0] = 0; p_valid[1] = 0;
      drive_inputs();
      RSTN = 1'b0;
      #2;
      chk("reset_outputs",
          {req1_ready, req0_ready, busy, rsp1_valid, rsp1_err, rsp0_valid, rsp0_err, enb, web,
           addrb, dinb, rsp0_rdata, rsp1_rdata}, 160'd0);
      m_act  = 1'b0;
      m_last = 1;
      @(posedge CLK);
      #2;
      RSTN = 1'b1;
      cyc++;
   endtask

   task automatic run_txn(input int id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit e_err, input logic [31:0] e_rdata, input int e_lat, input string name);
      p_valid[id] = 1; p_we[id] = we; p_addr[id] = addr; p_wdata[id] = wdata;
      obs_seen[id] = 0;
      acc_cyc[id]  = -1;
      for (int k = 0; k < 30 && !obs_seen[id]; k++) step();
      if (!obs_seen[id]) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got no response expected response within 30 cycles", name);
         p_valid[id] = 0;
      end else begin
         chk({name, "_err"},   obs_err[id],   e_err);
         chk({name, "_rdata"}, obs_rdata[id], e_rdata);
         chk({name, "_lat"},   obs_cyc[id] - acc_cyc[id], e_lat);
      end
   endtask

   typedef struct {
      int          id;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vt [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{0, 0, 32'd1,         32'd0,          0, 32'd15,         4};
      vt[1] = '{1, 1, 32'd40,        32'hDEADBEEF,   0, 32'd0,          2};
      vt[2] = '{1, 0, 32'd40,        32'd0,          0, 32'hDEADBEEF,   4};
      vt[3] = '{0, 0, 32'd50,        32'd0,          1, 32'd0,          1};
      vt[4] = '{0, 0, 32'd49,        32'd0,          0, 32'd777,        4};
      vt[5] = '{0, 1, 32'd49,        32'h12345678,   0, 32'd0,          2};
      vt[6] = '{1, 0, 32'd49,        32'd0,          0, 32'h12345678,   4};
      vt[7] = '{1, 0, 32'hFFFFFFFF,  32'd0,          1, 32'd0,          1};
      vt[8] = '{1, 1, 32'd50,        32'h0BADF00D,   1, 32'd0,          1};
      vt[9] = '{0, 0, 32'd50,        32'd0,          1, 32'd0,          1};

      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      ref_mem[1]  = 32'd15;
      ref_mem[49] = 32'd777;
      for (int n = 0; n < 2; n++) begin
         p_valid[n] = 0; p_we[n] = 0; p_addr[n] = 0; p_wdata[n] = 0;
         obs_seen[n] = 0; acc_cyc[n] = -1;
      end
      cyc = 0; m_act = 0; m_last = 1; m_t = 0; m_lat = 0; m_id = 0;
      RSTN = 1'b1;
      drive_inputs();
      #1;
      apply_reset();

      // Round-robin from reset: both read word 49 continuously.
      dut_grants.delete();
      for (int n = 0; n < 2; n++) begin
         p_valid[n] = 1; p_we[n] = 0; p_addr[n] = 32'd49; p_wdata[n] = 0;
      end
      for (int k = 0; k < 60 && dut_grants.size() < 4; k++) begin
         step();
         for (int n = 0; n < 2; n++) if (!p_valid[n] && dut_grants.size() < 4) p_valid[n] = 1;
      end
      for (int k = 0; k < 12; k++) step();
      chk("rr_grant_count_ge4", dut_grants.size() >= 4, 1'b1);
      if (dut_grants.size() >= 4)
         for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), dut_grants[i], i % 2);

      for (int i = 0; i < 10; i++)
         run_txn(vt[i].id, vt[i].we, vt[i].addr, vt[i].wdata,
                 vt[i].exp_err, vt[i].exp_rdata, vt[i].exp_lat, $sformatf("vec%0d", i));
      for (int k = 0; k < 3; k++) step();

      // Reset during RD1 of a read: no response may follow release.
      p_valid[0] = 1; p_we[0] = 0; p_addr[0] = 32'd1;
      acc_cyc[0] = -1;
      for (int k = 0; k < 10 && acc_cyc[0] < 0; k++) step();
      step();
      step();
      apply_reset();
      obs_seen[0] = 0; obs_seen[1] = 0;
      for (int k = 0; k < 8; k++) step();
      chk("no_rsp_after_reset", {obs_seen[1], obs_seen[0]}, 2'b00);
      run_txn(0, 0, 32'd1, 32'd0, 0, 32'd15, 4, "post_reset_rd");

      // Random traffic against the reference model.
      for (int k = 0; k < 1500; k++) begin
         for (int n = 0; n < 2; n++) begin
            if (!p_valid[n] && $urandom_range(0, 3) == 0) begin
               p_valid[n] = 1;
               p_we[n]    = $urandom_range(0, 1) == 1;
               case ($urandom_range(0, 9))
                  0:       p_addr[n] = $urandom;
                  1, 2, 3: p_addr[n] = $urandom_range(0, 3);
                  default: p_addr[n] = $urandom_range(0, 55);
               endcase
               p_wdata[n] = $urandom;
            end
         end
         step();
      end
      for (int k = 0; k < 20 && (p_valid[0] || p_valid[1]); k++) step();
      for (int k = 0; k < 6; k++) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter: DEPTH, default 50, number of 32-bit words in the attached BRAM; addresses >= DEPTH are illegal.
REQ-002 Port: CLK  in  1  single clock; all logic on rising edge.
REQ-003 Port: RSTN  in  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid / req1_valid  in  1  requester n has a pending access.
REQ-005 Port: req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready).
REQ-006 Port: req0_we / req1_we  in  1  1 = write, 0 = read.
REQ-007 Port: req0_addr / req1_addr  in  32  word address.
REQ-008 Port: req0_wdata / req1_wdata  in  32  write data.
REQ-009 Port: rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse to requester n.
REQ-010 Port: rsp0_rdata / rsp1_rdata  out  32  read data, valid with rsp_valid; 0 for writes and errors.
REQ-011 Port: rsp0_err / rsp1_err  out  1  address out of range, valid with rsp_valid.
REQ-012 Port: addrb  out  32  BRAM word address.
REQ-013 Port: dinb  out  32  BRAM write data.
REQ-014 Port: doutb  in  32  BRAM read data, 2 registered stages after addrb, gated by enb at every stage.
REQ-015 Port: enb  out  1  BRAM enable.
REQ-016 Port: web  out  4  BRAM write strobe; 4'hF writes, 4'h0 holds.
REQ-017 Port: busy  out  1  high whenever state != IDLE.

Function
REQ-018 States SHALL be IDLE, RD0, RD1, RD2, WR, ERR, RSP; one access in flight at a time.
REQ-019 In IDLE, reqN_ready SHALL be combinational: high only for the requester granted this cycle; never both high.
REQ-020 Arbitration SHALL be round-robin.
- Only one valid: that requester is granted.
- Both valid: the requester not granted last is granted.
- last_grant updates on each acceptance.
REQ-021 Requesters SHALL hold valid, we, addr and wdata stable until ready; the arbiter SHALL latch addr, we, wdata and the requester id on acceptance.
REQ-022 Accept in cycle T, addr >= DEPTH: next state ERR.
- No BRAM activity (enb=0, web=0).
- rspN_valid=1, err=1, rdata=0 in T+1; then IDLE.
REQ-023 Accept of a legal read in T: RD0 (T+1), RD1 (T+2), RD2 (T+3).
- enb=1, web=0 and addrb held at the latched address in all three cycles.
- doutb captured at the end of T+3.
REQ-024 For a read, state RSP in T+4: rspN_valid=1, rdata=captured word, err=0; then IDLE (ready possible again in T+5).
REQ-025 Accept of a legal write in T: WR in T+1 with addrb=addr, dinb=wdata, web=4'hF, enb=1; memory updates at the end of T+1.
REQ-026 For a write, state RSP in T+2: rspN_valid=1, rdata=0, err=0.
REQ-027 Outside RD0/RD1/RD2/WR: enb=0, web=4'h0, addrb=0, dinb=0; web SHALL be 4'hF only in WR.
REQ-028 rsp valid SHALL be routed only to the requester that issued the access; the other requester's rsp_valid stays 0.
REQ-029 A requester SHALL NOT be granted again before its previous rsp_valid pulse; requests arriving while busy wait with ready=0.
REQ-030 Read-after-write to the same address, issued back-to-back by either requester, SHALL return the newly written data.

Reset
REQ-031 RSTN low SHALL immediately force:
- state=IDLE, last_grant=1 (requester 0 wins the first tie)
- all ready/rsp_valid/rsp_err=0, rsp_rdata=0, busy=0
- enb=0, web=0, addrb=0, dinb=0
REQ-032 Reset mid-access SHALL drop the in-flight response with no rsp_valid after release; a write interrupted in WR has undefined memory effect.
REQ-033 After RSTN deasserts, a request SHALL be acceptable in the first clock edge cycle.

Verification
REQ-034 BRAM model preloaded word1=15, word49=777; req0 read addr 1 accepted at T -> enb=1 T+1..T+3, rsp0_valid at T+4 with rdata=15, err=0.
REQ-035 req1 write addr 40 data 0xDEADBEEF, then req1 read addr 40 -> web=4'hF only in T+1, rsp1_valid at T+2; read returns 0xDEADBEEF.
REQ-036 Both valid from reset, each reading addr 49 repeatedly -> grants alternate 0,1,0,1.
- Each rsp pulse only on the granting side with rdata=777.
- Never both ready high.
REQ-037 req0 read addr 50 (DEPTH) -> rsp0_valid at T+1, err=1, rdata=0, enb never asserted.
REQ-038 RSTN low during RD1 of a read -> all outputs zero asynchronously, no rsp pulse after release, next request serviced normally.
